// File: rtl/uart_msg_pkg.sv
// Shared UART message definitions: byte codes used by both link directions
// and the receive-side game FSM state encoding.
package uart_msg_pkg;

  localparam logic [7:0] MSG_READY = 8'h52;  // 'R'
  localparam logic [7:0] MSG_LOST  = 8'h4C;  // 'L'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PEER,
    ST_PLAYING,
    ST_WON,
    ST_LINK_DOWN
  } state_t;

endpackage

// File: rtl/uart_msg_decoder_if.sv
// RX FIFO read port between the UART receive FIFO and the message decoder.
interface uart_msg_decoder_if;

  // A byte transfers on every cycle where valid (!rx_empty) and ready
  // (rd_uart) are both high; r_data is the show-ahead head of the FIFO and
  // must be stable while rx_empty=0. The decoder always accepts.
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (
    input  rx_empty,
    input  r_data,
    output rd_uart
  );

  modport slave (
    output rx_empty,
    output r_data,
    input  rd_uart
  );

endinterface

// File: rtl/link_watchdog.sv
// Idle-link timer: counts enabled cycles since the last kick and flags
// expiry once TIMEOUT_CYC cycles have passed without one.
module link_watchdog #(
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int              T_W    = $clog2(TIMEOUT_CYC);
  localparam logic [T_W-1:0]  T_LAST = T_W'(TIMEOUT_CYC - 1);

  logic [T_W-1:0] t_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_cnt <= '0;
    end else if (!enable || kick) begin
      t_cnt <= '0;
    end else if (t_cnt != T_LAST) begin
      t_cnt <= t_cnt + 1'b1;
    end
  end

  // A valid byte arriving in the final cycle still counts as a live link.
  assign expired = enable && !kick && (t_cnt == T_LAST);

endmodule

// File: rtl/uart_msg_decoder.sv
// Receive-side multiplayer message interpreter: drains the RX FIFO, decodes
// peer 'R'/'L' messages, drives the start/victory handshakes and link timeout.
module uart_msg_decoder
  import uart_msg_pkg::*;
#(
  parameter int R_COUNT     = 4,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               multiplayer,
  input  logic               local_ready,
  input  logic               clear,
  uart_msg_decoder_if.master rx,
  output logic               peer_ready,
  output logic               start_game,
  output logic               peer_lost,
  output logic               link_lost,
  output logic [7:0]         last_char,
  output logic [ERR_W-1:0]   err_count,
  output state_t             dbg_state
);

  localparam int              RC_W  = $clog2(R_COUNT + 1);
  localparam logic [RC_W-1:0] R_SAT = RC_W'(R_COUNT);

  state_t          state, state_next;
  logic [RC_W-1:0] r_cnt, r_cnt_next;
  logic            pop, is_ready, is_lost, is_other;
  logic            peer_ok, wd_enable, expired, err_inc;

  // The FIFO is drained unconditionally so it can never back up.
  assign rx.rd_uart = rst_n & ~rx.rx_empty;
  assign pop        = rx.rd_uart;
  assign is_ready   = pop && (rx.r_data == MSG_READY);
  assign is_lost    = pop && (rx.r_data == MSG_LOST);
  assign is_other   = pop && !is_ready && !is_lost;

  assign peer_ok    = (r_cnt == R_SAT);
  assign wd_enable  = multiplayer && ((state == ST_WAIT_PEER) || (state == ST_PLAYING));
  assign err_inc    = is_other && multiplayer && (state != ST_WON) && !(&err_count);

  link_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (wd_enable),
    .kick   (is_ready | is_lost),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      state <= state_next;
      r_cnt <= r_cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    r_cnt_next = r_cnt;
    start_game = 1'b0;
    if (!multiplayer) begin
      state_next = ST_IDLE;
      r_cnt_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (local_ready) state_next = ST_WAIT_PEER;
        end
        ST_WAIT_PEER: begin
          if (is_ready)  r_cnt_next = peer_ok ? r_cnt : r_cnt + 1'b1;
          else if (pop)  r_cnt_next = '0;
          // 'L' has no meaning here, even on the start cycle.
          if (!local_ready) begin
            state_next = ST_IDLE;
            r_cnt_next = '0;
          end else if (peer_ok) begin
            start_game = 1'b1;
            state_next = ST_PLAYING;
            r_cnt_next = '0;
          end else if (expired) begin
            state_next = ST_LINK_DOWN;
            r_cnt_next = '0;
          end
        end
        ST_PLAYING: begin
          if (is_lost)      state_next = ST_WON;
          else if (expired) state_next = ST_LINK_DOWN;
        end
        ST_WON: begin
          if (clear) state_next = ST_IDLE;
        end
        ST_LINK_DOWN: begin
          if (clear) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_char <= '0;
      err_count <= '0;
    end else begin
      if (pop)     last_char <= rx.r_data;
      if (err_inc) err_count <= err_count + 1'b1;
    end
  end

  assign peer_ready = (state == ST_PLAYING) || ((state == ST_WAIT_PEER) && peer_ok);
  assign peer_lost  = (state == ST_WON);
  assign link_lost  = (state == ST_LINK_DOWN);
  assign dbg_state  = state;

endmodule
